// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small input FIFO; queued words are sent back-to-back,
// LSB first, with optional parity and one or two stop bits.
module uart_tx_fifo #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                              Clk,
  input  logic                              Rst_n,
  output logic                              Tx,
  input  logic [DATA_BITS-1:0]              S_axis_tdata,
  input  logic                              S_axis_tvalid,
  output logic                              S_axis_tready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   Fifo_count,
  output logic                              Busy
);

  localparam int unsigned CYC_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W = $clog2(DATA_BITS);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [CYC_W-1:0]     cyc_q, cyc_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 tx_q, tx_d;
  logic                 tready_q, tready_d;
  logic                 busy_q, busy_d;
  logic                 push, pop, bit_end;
  logic [DATA_BITS-1:0] head;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];

  // FIFO storage; stale entries are harmless because the pointers are reset
  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr_q] <= S_axis_tdata;
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q  <= S_IDLE;
      cyc_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      tx_q     <= 1'b1;
      tready_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      tx_q     <= tx_d;
      tready_q <= tready_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    pop      = 1'b0;
    push     = S_axis_tvalid && tready_q;
    head     = mem[rd_ptr_q];
    bit_end  = (cyc_q == CYC_LAST);
    cyc_d    = bit_end ? '0 : cyc_q + CYC_W'(1);

    case (state_q)
      S_IDLE: begin
        cyc_d = '0;
        bit_d = '0;
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == DATA_LAST) begin
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
            bit_d   = '0;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          bit_d   = '0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            bit_d = '0;
            // Chain straight into the next start bit when a word is waiting
            if (count_q != '0) begin
              pop     = 1'b1;
              state_d = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      shift_d = head;
      par_d   = (PARITY == 2) ? ^head : ~^head;
    end

    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push && pop) count_d = count_q - CNT_W'(1);

    // Line level and flags follow the next state so they change on the same edge
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
    tready_d = (count_d < CNT_W'(FIFO_DEPTH));
    busy_d   = (state_d != S_IDLE) || (count_d != '0);
  end

  assign Tx            = tx_q;
  assign S_axis_tready = tready_q;
  assign Fifo_count    = count_q;
  assign Busy          = busy_q;

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an input FIFO. It accepts words on an AXI-Stream-style slave port and serialises them on a single Tx line, least significant bit first. Word width, bit period, parity mode and stop-bit count are compile-time parameters. Queued words go out back-to-back with no idle gap between frames. The block sits between the core's byte-stream producer and the board UART pin, and succeeds the fixed 8N1, 16-clock, unbuffered transmitter.

## Interface
- DATA_BITS, 8: data bits per frame; legal range 5..9.
- CLKS_PER_BIT, 16: Clk cycles per serial bit; must be ≥ 2.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: number of stop bits, 1 or 2.
- FIFO_DEPTH, 4: input FIFO entries; power of two, ≥ 2.
- Clk  input  1  the block's only clock; all logic on the rising edge.
- Rst_n  input  1  synchronous, active-low reset.
- Tx  output  1  serial line; registered; idles at 1.
- S_axis_tdata  input  DATA_BITS  word to transmit.
- S_axis_tvalid  input  1  producer has a word.
- S_axis_tready  output  1  registered; high when the FIFO can accept a word.
- Fifo_count  output  $clog2(FIFO_DEPTH+1)  words held in the FIFO, excluding the word being shifted.
- Busy  output  1  high while a frame is on the line or the FIFO is non-empty.

## Operation
- Transfer: occurs on a rising edge where S_axis_tvalid && S_axis_tready; tdata is written at the FIFO tail.
- tready is computed from the next-state count and is high iff next_count < FIFO_DEPTH. It has no combinational path from tvalid.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if FIFO non-empty, pop the head into the shift register and go to START; otherwise stay.
  - START: Tx = 0 for CLKS_PER_BIT cycles → DATA.
  - DATA: Tx = shift[0]; shift right every CLKS_PER_BIT cycles. After DATA_BITS bits → PARITY if PARITY != 0, else STOP.
  - PARITY: Tx = ^word for even parity, ~^word for odd parity; CLKS_PER_BIT cycles → STOP.
  - STOP: Tx = 1 for STOP_BITS × CLKS_PER_BIT cycles. At its end, if FIFO non-empty, pop and go directly to START (no IDLE cycle); otherwise go to IDLE.
- Counters:
  - Cycle counter is $clog2(CLKS_PER_BIT) bits wide and runs 0..CLKS_PER_BIT−1. It clears on every state entry and wraps at the bit boundary.
  - Bit counter covers 0..DATA_BITS−1 in DATA and 0..STOP_BITS−1 in STOP.
- Parity is computed over the popped word at pop time, not over S_axis_tdata.
- Simultaneous push and pop: Fifo_count is unchanged, and pointers advance modulo FIFO_DEPTH.
- Full: while Fifo_count == FIFO_DEPTH, tready = 0 even during a pop cycle. It rises on the edge after the pop.
- Empty: no pop occurs; the FSM holds IDLE with Tx = 1.
- Busy = (state != IDLE) || (Fifo_count != 0).

## Timing
- Reset values: Tx = 1, S_axis_tready = 0, Fifo_count = 0, Busy = 0, state = IDLE; FIFO pointers cleared.
- S_axis_tready goes to 1 on the first edge with Rst_n = 1.
- Reset mid-frame: at the reset edge, Tx returns to 1, the frame is truncated, and the FIFO is flushed. No partial frame resumes.
- Latency: with the word accepted at edge E0 into an empty FIFO and FSM in IDLE:
  - E1: pop occurs, Tx = 0 (start bit).
  - Frame occupies the line for F = CLKS_PER_BIT × (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) cycles.
- Back-to-back: the next start bit begins on the edge immediately after the last stop-bit cycle.
- Throughput: one word per F cycles. The FIFO absorbs bursts of up to FIFO_DEPTH words plus the one in flight.
- Fifo_count and tready update on the same edge as the transfer or pop that changes them.

## Test plan
- Defaults (8N1, 16 clocks per bit), send 0xA5:
  - Tx from E1 reads 0,1,0,1,0,0,1,0,1,1, each level held 16 cycles (160 total).
  - Busy falls on the following edge.
- PARITY=2, send 0x07: parity bit = 1, frame 176 cycles. Same word with PARITY=1: parity bit = 0.
- DATA_BITS=7, STOP_BITS=2, CLKS_PER_BIT=4, send 0x55:
  - 7 data bits alternate 1,0,…,1.
  - Stop high for 8 cycles; frame 40 cycles.
- Defaults, tvalid held high with 6 words (0x01..0x06):
  - 5 words accepted in consecutive cycles; tready drops when Fifo_count = 4.
  - 6th word accepted one cycle after the first stop-bit end.
  - All six frames contiguous (960 cycles), no idle cycle between frames.
- Push and pop on the same edge at Fifo_count = 2: count stays 2 and word order is preserved.
- Rst_n low for 1 cycle during data bit 3 with 2 words queued:
  - Tx = 1, Fifo_count = 0, tready = 0 after the reset edge.
  - tready = 1 on the next edge; no further frame is transmitted.
